// File: rtl/layer_mac_sequencer.sv
// rtl/layer_mac_sequencer.sv - time-multiplexed signed fixed-point MAC for one fully-connected layer
//
// Purpose: computes out[n] = sat((sum_j in[j]*w[n*P+j] + (b[n] << FRAC_BITS)) >>> FRAC_BITS)
//          for n = 0..NEURONS-1 with a single multiplier, optional ReLU on the result.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, relu_en             run request (IDLE only), ReLU select latched at start
//   busy, done                 not-IDLE flag, one-cycle completion pulse
//   rd_en, in_addr, w_addr,    read strobe and addresses for the input, weight and
//   b_addr                     bias memories (synchronous, data valid one cycle later)
//   in_data, w_data, b_data    memory read data
//   out_valid, out_addr,       one strobe per neuron carrying its index and result
//   out_data

module layer_mac_sequencer #(
    parameter int NEURONS            = 2,
    parameter int PREV_LAYER_OUTPUTS = 3,
    parameter int DATA_W             = 32,
    parameter int FRAC_BITS          = 24,
    // Address widths; a single-entry memory still gets a 1-bit address.
    localparam int IN_AW = (PREV_LAYER_OUTPUTS > 1) ? $clog2(PREV_LAYER_OUTPUTS) : 1,
    localparam int W_AW  = (NEURONS * PREV_LAYER_OUTPUTS > 1) ?
                           $clog2(NEURONS * PREV_LAYER_OUTPUTS) : 1,
    localparam int N_AW  = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic [N_AW-1:0]   b_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              out_valid,
    output logic [N_AW-1:0]   out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam int ACC_W = 2 * DATA_W;
    // Two guard bits so accumulator plus shifted bias can never wrap before saturation.
    localparam int SUM_W = ACC_W + 2;

    localparam logic [IN_AW-1:0] J_LAST = IN_AW'(PREV_LAYER_OUTPUTS - 1);
    localparam logic [N_AW-1:0]  N_LAST = N_AW'(NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic [IN_AW-1:0]          j_q;
    logic [N_AW-1:0]           n_q;
    logic [W_AW-1:0]           w_q;
    logic                      relu_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  bias_q;
    // dvalid_q: memory data in this cycle belongs to an address issued last cycle.
    // dfirst_q: that address was j=0, so b_data is the bias of the current neuron.
    logic                      dvalid_q;
    logic                      dfirst_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      rd_en_q;
    logic                      out_valid_q;
    logic [N_AW-1:0]           out_addr_q;
    logic [DATA_W-1:0]         out_data_q;

    logic signed [ACC_W-1:0]   prod_w;
    logic signed [ACC_W-1:0]   acc_sum_w;
    logic signed [DATA_W-1:0]  bias_eff_w;
    logic signed [SUM_W-1:0]   sum_w;
    logic signed [SUM_W-1:0]   shift_w;
    logic [DATA_W-1:0]         sat_d;
    logic [DATA_W-1:0]         out_data_d;

    assign prod_w    = ACC_W'($signed(in_data)) * ACC_W'($signed(w_data));
    assign acc_sum_w = acc_q + prod_w;

    // With a single input per neuron the bias arrives in DRAIN itself, before
    // bias_q could have captured it.
    assign bias_eff_w = dfirst_q ? $signed(b_data) : bias_q;

    // The result is formed in DRAIN from the accumulator plus the last product so
    // that out_data can be registered on entry to WRITE.
    assign sum_w   = SUM_W'(acc_sum_w) + (SUM_W'(bias_eff_w) <<< FRAC_BITS);
    assign shift_w = sum_w >>> FRAC_BITS;

    always_comb begin
        sat_d = shift_w[DATA_W-1:0];
        // Out of range when the bits above the result sign are not a pure sign extension.
        if (!(&shift_w[SUM_W-1:DATA_W-1]) && (|shift_w[SUM_W-1:DATA_W-1])) begin
            sat_d = shift_w[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end
        out_data_d = (relu_q && sat_d[DATA_W-1]) ? '0 : sat_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            j_q         <= '0;
            n_q         <= '0;
            w_q         <= '0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            bias_q      <= '0;
            dvalid_q    <= 1'b0;
            dfirst_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dvalid_q    <= rd_en_q;
            dfirst_q    <= rd_en_q && (j_q == '0);

            if (dvalid_q) begin
                acc_q <= acc_sum_w;
            end
            if (dfirst_q) begin
                bias_q <= $signed(b_data);
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        j_q     <= '0;
                        n_q     <= '0;
                        w_q     <= '0;
                        relu_q  <= relu_en;
                    end
                end
                S_ISSUE: begin
                    // Nothing is in flight at j=0 (previous state was IDLE or WRITE),
                    // so the clear never collides with an accumulation.
                    if (j_q == '0) begin
                        acc_q <= '0;
                    end
                    if (j_q == J_LAST) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        j_q <= j_q + IN_AW'(1);
                        w_q <= w_q + W_AW'(1);
                    end
                end
                S_DRAIN: begin
                    state_q     <= S_WRITE;
                    out_valid_q <= 1'b1;
                    out_addr_q  <= n_q;
                    out_data_q  <= out_data_d;
                end
                S_WRITE: begin
                    if (n_q == N_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ISSUE;
                        rd_en_q <= 1'b1;
                        n_q     <= n_q + N_AW'(1);
                        j_q     <= '0;
                        // Weights are laid out neuron-major, so the next row follows on.
                        w_q     <= w_q + W_AW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign in_addr   = j_q;
    assign w_addr    = w_q;
    assign b_addr    = n_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb/tb_layer_mac_sequencer.sv - self-checking bench for layer_mac_sequencer

module tb_layer_mac_sequencer;

    localparam int N  = 2;
    localparam int P  = 3;
    localparam int PD = P + 2;
    localparam int DC = N * PD + 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, relu_en;
    logic        busy, done, rd_en, out_valid;
    logic [1:0]  in_addr;
    logic [2:0]  w_addr;
    logic [0:0]  b_addr, out_addr;
    logic [31:0] in_data, w_data, b_data, out_data;

    layer_mac_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .busy(busy), .done(done), .rd_en(rd_en),
        .in_addr(in_addr), .w_addr(w_addr), .b_addr(b_addr),
        .in_data(in_data), .w_data(w_data), .b_data(b_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
    );

    logic        start1, relu1, busy1, done1, rd1, ov1;
    logic [0:0]  ia1, wa1, ba1, oa1;
    logic [31:0] id1, wd1, bd1, od1;

    layer_mac_sequencer #(.NEURONS(1), .PREV_LAYER_OUTPUTS(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .relu_en(relu1),
        .busy(busy1), .done(done1), .rd_en(rd1),
        .in_addr(ia1), .w_addr(wa1), .b_addr(ba1),
        .in_data(id1), .w_data(wd1), .b_data(bd1),
        .out_valid(ov1), .out_addr(oa1), .out_data(od1)
    );

    logic [31:0] in_mem [4];
    logic [31:0] w_mem  [8];
    logic [31:0] b_mem  [2];
    logic [31:0] p1_in, p1_w, p1_b;

    always @(posedge clk) begin
        if (rd_en) begin
            in_data <= in_mem[in_addr];
            w_data  <= w_mem[w_addr];
            b_data  <= b_mem[b_addr];
        end
        if (rd1) begin
            id1 <= p1_in;
            wd1 <= p1_w;
            bd1 <= p1_b;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: dot product in 64-bit wrapping arithmetic, add bias scaled to the
    // product format, floor-divide by 2^FRAC, clamp to 32-bit, optional ReLU.
    function automatic logic [31:0] ref_calc(input logic [31:0] xin [4],
                                             input logic [31:0] wgt [8],
                                             input logic [31:0] bia [2],
                                             input int n, input bit relu, input int np);
        longint acc = 0;
        logic signed [65:0] s;
        for (int j = 0; j < np; j++)
            acc += longint'($signed(xin[j])) * longint'($signed(wgt[n*np+j]));
        s = 66'(acc) + 66'($signed(bia[n])) * 66'sd16777216;
        s = s >>> 24;
        if (s > 66'sd2147483647)       s = 66'sd2147483647;
        else if (s < -66'sd2147483648) s = -66'sd2147483648;
        if (relu && s < 0) s = 0;
        return s[31:0];
    endfunction

    function automatic logic [31:0] rnd();
        logic [31:0] x = $urandom;
        if ($urandom_range(0, 1) == 1) x = 32'($signed(x) >>> 6);
        return x;
    endfunction

    // One layer run on u_dut. Cycle k counts clock periods after the start edge.
    // st_a/st_b: cycles holding start high; flip_at: cycle relu_en is inverted;
    // rst_at: cycle reset is asserted (0 = none).
    task automatic run_layer(input string tag, input bit relu,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input int st_a, input int st_b, input int flip_at,
                             input int rst_at, input int ncyc);
        logic [31:0] exp_d [2];
        int vcnt = 0, dcnt = 0, bfirst = -1, blast = -1, lim, exp_v;
        exp_d[0] = e0;
        exp_d[1] = e1;
        @(negedge clk);
        relu_en = relu;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (busy) begin
                if (bfirst < 0) bfirst = k;
                blast = k;
            end
            if (out_valid) begin
                if (vcnt < N) begin
                    chk({tag, " out_addr"}, out_addr, vcnt);
                    chk({tag, " out_data"}, out_data, exp_d[vcnt]);
                    chk({tag, " out_cycle"}, k, (vcnt + 1) * PD);
                end
                vcnt++;
            end
            if (done) begin
                dcnt++;
                chk({tag, " done_cycle"}, k, DC);
            end
            if (rst_at == 0 || k <= rst_at) begin
                automatic bit exp_rd = (k < DC) && (((k - 1) % PD) < P);
                chk({tag, " rd_en"}, rd_en, exp_rd);
                if (exp_rd && rd_en) begin
                    chk({tag, " in_addr"}, in_addr, (k - 1) % PD);
                    chk({tag, " w_addr"}, w_addr, ((k - 1) / PD) * P + (k - 1) % PD);
                    chk({tag, " b_addr"}, b_addr, (k - 1) / PD);
                end
            end
            start = (k == st_a) || (k == st_b);
            if (k == flip_at) relu_en = ~relu_en;
            if (rst_at > 0 && k == rst_at + 1) rst_n = 1'b1;
            if (rst_at > 0 && k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " async_reset_outputs"},
                    {busy, done, rd_en, out_valid, out_addr, out_data, in_addr, w_addr, b_addr}, 0);
            end
        end
        lim   = (rst_at > 0) ? rst_at : ncyc;
        exp_v = 0;
        for (int n = 0; n < N; n++) if ((n + 1) * PD <= lim) exp_v++;
        chk({tag, " strobe_count"}, vcnt, exp_v);
        chk({tag, " done_count"}, dcnt, (DC <= lim) ? 1 : 0);
        chk({tag, " busy_first"}, bfirst, 1);
        chk({tag, " busy_last"}, blast, (lim < DC) ? lim : DC);
    endtask

    task automatic run_p1(input string tag, input bit relu, input logic [31:0] e);
        int vcnt = 0, dcnt = 0, rcnt = 0, blast = -1;
        @(negedge clk);
        relu1  = relu;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (busy1) blast = k;
            if (rd1) begin
                rcnt++;
                chk({tag, " rd_cycle"}, k, 1);
                chk({tag, " addrs"}, {ia1, wa1, ba1}, 0);
            end
            if (ov1) begin
                vcnt++;
                chk({tag, " out_data"}, od1, e);
                chk({tag, " out_addr"}, oa1, 0);
                chk({tag, " out_cycle"}, k, 3);
            end
            if (done1) begin
                dcnt++;
                chk({tag, " done_cycle"}, k, 4);
            end
        end
        chk({tag, " rd_count"}, rcnt, 1);
        chk({tag, " strobe_count"}, vcnt, 1);
        chk({tag, " done_count"}, dcnt, 1);
        chk({tag, " busy_last"}, blast, 4);
    endtask

    typedef struct {
        logic [31:0] xin [4];
        logic [31:0] wgt [8];
        logic [31:0] bia [2];
        bit          relu;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [6];

    task automatic load(input vec_t v);
        for (int i = 0; i < 4; i++) in_mem[i] = v.xin[i];
        for (int i = 0; i < 8; i++) w_mem[i]  = v.wgt[i];
        for (int i = 0; i < 2; i++) b_mem[i]  = v.bia[i];
    endtask

    initial begin
        vecs[0] = '{'{32'h01000000, 32'h00800000, 32'h00400000, 0},
                    '{32'h00800000, 32'h00800000, 32'h00800000, 32'h01000000, 0, 32'hFF800000, 0, 0},
                    '{0, 32'h00400000}, 1'b0, 32'd14680064, 32'd18874368};
        vecs[1] = '{'{32'h7F000000, 0, 0, 0},
                    '{32'h02000000, 0, 0, 32'hFE000000, 0, 0, 0, 0},
                    '{0, 0}, 1'b0, 32'h7FFFFFFF, 32'h80000000};
        vecs[2] = '{'{32'hFFFFFFFF, 0, 0, 0},
                    '{1, 0, 0, 1, 0, 0, 0, 0},
                    '{0, 32'h01000000}, 1'b0, 32'hFFFFFFFF, 32'h00FFFFFF};
        vecs[3] = '{'{32'hFFFFFFFF, 0, 0, 0},
                    '{1, 0, 0, 1, 0, 0, 0, 0},
                    '{0, 32'h01000000}, 1'b1, 32'h00000000, 32'h00FFFFFF};
        vecs[4] = '{'{32'h01000000, 32'h01000000, 32'h01000000, 0},
                    '{32'hFF000000, 32'hFF000000, 32'hFF000000, 32'h00800000, 32'h00800000, 32'h00800000, 0, 0},
                    '{32'h01000000, 32'hFE000000}, 1'b1, 32'h00000000, 32'h00000000};
        vecs[5] = vecs[4];
        vecs[5].relu = 1'b0;
        vecs[5].e0   = 32'hFE000000;
        vecs[5].e1   = 32'hFF800000;

        rst_n = 1'b0; start = 1'b0; relu_en = 1'b0; start1 = 1'b0; relu1 = 1'b0;
        p1_in = 0; p1_w = 0; p1_b = 0;
        load(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {busy, done, rd_en, out_valid, out_addr, out_data, in_addr, w_addr, b_addr}, 0);
        chk("reset_outputs_p1", {busy1, done1, rd1, ov1, oa1, od1, ia1, wa1, ba1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            load(vecs[i]);
            run_layer($sformatf("vec%0d", i), vecs[i].relu, vecs[i].e0, vecs[i].e1, 0, 0, 0, 0, 14);
        end

        load(vecs[0]);
        run_layer("start_ignored", 1'b0, vecs[0].e0, vecs[0].e1, 2, 11, 0, 0, 11);
        run_layer("restart_after_done", 1'b0, vecs[0].e0, vecs[0].e1, 0, 0, 0, 0, 14);

        run_layer("reset_mid_op", 1'b0, vecs[0].e0, vecs[0].e1, 0, 0, 0, 7, 14);
        run_layer("after_reset", 1'b0, vecs[0].e0, vecs[0].e1, 0, 0, 0, 0, 14);

        load(vecs[5]);
        run_layer("relu_flip_on", 1'b0, vecs[5].e0, vecs[5].e1, 0, 0, 3, 0, 14);
        run_layer("relu_flip_off", 1'b1, 32'h0, 32'h0, 0, 0, 3, 0, 14);

        p1_in = 32'hFFFFFFFF; p1_w = 32'h1; p1_b = 32'h0;
        run_p1("p1_trunc", 1'b0, 32'hFFFFFFFF);
        run_p1("p1_relu", 1'b1, 32'h00000000);
        p1_in = 32'h00C00000; p1_w = 32'h02000000; p1_b = 32'hFF000000;
        run_p1("p1_bias", 1'b0, 32'h00800000);

        for (int r = 0; r < 10; r++) begin
            automatic bit relu = 1'($urandom_range(0, 1));
            automatic vec_t v;
            for (int i = 0; i < 4; i++) v.xin[i] = (i < P) ? rnd() : 32'h0;
            for (int i = 0; i < 8; i++) v.wgt[i] = (i < N * P) ? rnd() : 32'h0;
            for (int i = 0; i < 2; i++) v.bia[i] = rnd();
            load(v);
            run_layer($sformatf("rand%0d", r), relu,
                      ref_calc(v.xin, v.wgt, v.bia, 0, relu, P),
                      ref_calc(v.xin, v.wgt, v.bia, 1, relu, P), 0, 0, 0, 0, 14);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
Sequential controller that computes one fully-connected layer by time-multiplexing a single signed Q7.24 multiply-accumulate over all neurons and inputs. It replaces the fully parallel combinational layer when area matters. It walks input, weight and bias memories through synchronous read ports. It emits one neuron result per output strobe, applies bias, optional ReLU and saturation, then reports completion.

Parameters:
NEURONS, 2, number of neurons (outputs) in the layer, >=1
PREV_LAYER_OUTPUTS, 3, inputs per neuron, >=1
DATA_W, 32, signed data/weight/bias width, Q7.24
FRAC_BITS, 24, fractional bits of the fixed-point format

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin layer computation; sampled only in IDLE
relu_en  input  1  apply ReLU to outputs; captured when start is accepted
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE state
rd_en  output  1  read strobe to input/weight/bias memories
in_addr  output  clog2(PREV_LAYER_OUTPUTS)  input vector index j
w_addr  output  clog2(NEURONS*PREV_LAYER_OUTPUTS)  weight index n*PREV_LAYER_OUTPUTS+j
b_addr  output  clog2(NEURONS)  bias index n
in_data  input  DATA_W  signed input, valid the cycle after its address
w_data  input  DATA_W  signed weight, valid the cycle after its address
b_data  input  DATA_W  signed bias, valid the cycle after its address
out_valid  output  1  result strobe, one cycle per neuron
out_addr  output  clog2(NEURONS)  neuron index of result
out_data  output  DATA_W  signed Q7.24 result

Behaviour:
- Reset: all outputs 0, state IDLE, counters and accumulator 0. Reset mid-operation aborts immediately. No further out_valid or done until a new start.
- States: IDLE -> ISSUE -> DRAIN -> WRITE -> (ISSUE for next neuron | DONE) -> IDLE.
- IDLE: start=1 at an edge moves to ISSUE with n=0, j=0 and latches relu_en. start is ignored in every other state, including DONE.
- ISSUE: lasts PREV_LAYER_OUTPUTS cycles, one per j. In each cycle: rd_en=1, in_addr=j, w_addr=n*P+j, b_addr=n. At j=0 the accumulator is cleared. After j=P-1, go to DRAIN.
- Read pipeline: the data for address j is consumed the following cycle.
  - The product in_data*w_data is a full-precision 64-bit signed value added into a 64-bit accumulator.
  - b_data is captured in the cycle following ISSUE j=0.
- DRAIN: 1 cycle, rd_en=0. Accumulates the last product.
- WRITE: 1 cycle, out_valid=1, out_addr=n. out_data is computed as follows:
  - s = (acc + (bias sign-extended <<< FRAC_BITS)) >>> FRAC_BITS, an arithmetic shift that truncates toward negative infinity.
  - Saturate to 0x7FFFFFFF / 0x80000000.
  - If relu_en is latched and the result is negative, output 0.
  - out_data holds its value outside WRITE; out_valid is 0 outside WRITE.
  - Then n increments: if n<NEURONS-1 go to ISSUE (j=0), else go to DONE.
- DONE: done=1 for 1 cycle, busy=1, then IDLE.
- Latency: per neuron, P+2 cycles.
  - done is high in cycle N*(P+2)+1 after the start edge; this is cycle 11 for the defaults.
  - The first out_valid is in cycle P+2.
- No backpressure: results are fire-and-forget.
- P=1 and N=1 must work with no state skipped.

Test Plan:
- Defaults. Inputs {16777216, 8388608, 4194304}; weights n0 {8388608 x3}, n1 {16777216, 0, -8388608}; biases {0, 4194304}; relu_en=0.
  -> out_addr 0 data 14680064 at cycle 5; out_addr 1 data 18874368 at cycle 10; done at cycle 11; busy cycles 1..11.
- Saturation: P=1, N=2, input 0x7F000000, weights {33554432, -33554432}, biases 0.
  -> out_data 0x7FFFFFFF, then 0x80000000.
- Truncation/ReLU: P=1, N=1, input -1 raw, weight 1 raw, bias 0.
  -> relu_en=0 gives 0xFFFFFFFF; rerun with relu_en=1 gives 0.
- Start ignored: pulse start during ISSUE and during DONE.
  -> exactly N out_valid strobes, a single done, return to IDLE. A start on the cycle after DONE begins a new run with identical results.
- Reset mid-op: assert rst_n=0 during neuron 1 ISSUE.
  -> all outputs 0 asynchronously; no out_valid or done afterward. A following start reproduces the scenario 1 values.
- relu_en toggled after start: change relu_en mid-run with a negative result expected.
  -> the output follows the relu_en value latched at start.
